// File: rtl/fht_frame_sched.sv
// Frame sequencer around fht_control: loads N samples into four banks, kicks the core,
// waits for completion, then streams the results out through a 2-entry skid FIFO.
module fht_frame_sched #(
    parameter int N     = 1024,
    parameter int A_BIT = 8,
    parameter int D_BIT = 16,
    parameter int TMO   = 65535
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iFRAME_GO,
    input  logic             iIN_VALID,
    input  logic [D_BIT-1:0] iIN_DATA,
    output logic             oIN_READY,
    output logic             oLD_WE,
    output logic [1:0]       oLD_BANK,
    output logic [A_BIT-1:0] oLD_ADDR,
    output logic [D_BIT-1:0] oLD_DATA,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic             oUL_RE,
    output logic [1:0]       oUL_BANK,
    output logic [A_BIT-1:0] oUL_ADDR,
    input  logic [D_BIT-1:0] iUL_DATA,
    output logic             oOUT_VALID,
    output logic [D_BIT-1:0] oOUT_DATA,
    input  logic             iOUT_READY,
    output logic             oOWNER,
    output logic             oBUSY,
    output logic             oFRAME_DONE,
    output logic             oERR_TMO
);

    localparam int KW = A_BIT + 2;
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [15:0]   RUN_MAX = 16'(TMO);
    localparam bit            TMO_ON  = (TMO != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_ARM,
        S_RUN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [KW-1:0]    k;
    logic [KW-1:0]    out_cnt;
    logic             issue_done;
    logic             start_cnt;
    logic [2:0]       arm_cnt;
    logic [15:0]      run_cnt;
    logic             rdy_q;
    logic             err;
    logic             set_err;
    logic             clr_err;

    logic [D_BIT-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             inflight;

    logic             ld_xfer;
    logic             pop;
    logic [2:0]       pending;
    logic             ul_re;
    logic             last_pop;
    logic             run_hit;

    assign ld_xfer  = (state == S_LOAD) && iIN_VALID;
    assign pop      = (fifo_cnt != 2'd0) && iOUT_READY;
    // A pop in this cycle frees its slot before the issued read lands, which keeps
    // full throughput with ready held high while still never overfilling the FIFO.
    assign pending  = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign ul_re    = (state == S_UNLOAD) && !issue_done && (pending < 3'd2);
    assign last_pop = pop && (out_cnt == K_LAST);
    assign run_hit  = TMO_ON && (run_cnt == RUN_MAX);

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        clr_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (iFRAME_GO) begin
                    state_nx = S_LOAD;
                    clr_err  = 1'b1;
                end
            end
            S_LOAD: begin
                if (ld_xfer && (k == K_LAST)) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (start_cnt) begin
                    state_nx = S_ARM;
                end
            end
            S_ARM: begin
                if (!iFHT_RDY) begin
                    state_nx = S_RUN;
                end else if (arm_cnt == 3'd7) begin
                    state_nx = S_IDLE;
                    set_err  = 1'b1;
                end
            end
            S_RUN: begin
                if (iFHT_RDY && !rdy_q) begin
                    state_nx = S_UNLOAD;
                end else if (run_hit) begin
                    state_nx = S_IDLE;
                    set_err  = 1'b1;
                end
            end
            S_UNLOAD: begin
                if (last_pop) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Every counter restarts whenever its owning state is (re)entered.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state      <= S_IDLE;
            k          <= '0;
            out_cnt    <= '0;
            issue_done <= 1'b0;
            start_cnt  <= 1'b0;
            arm_cnt    <= 3'd0;
            run_cnt    <= 16'd0;
            rdy_q      <= 1'b0;
            err        <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            inflight   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= iFHT_RDY;

            if (clr_err) begin
                err <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end

            if (state != state_nx) begin
                k <= '0;
            end else if (ld_xfer || ul_re) begin
                k <= k + KW'(1);
            end

            if (state != S_UNLOAD) begin
                issue_done <= 1'b0;
                out_cnt    <= '0;
            end else begin
                if (ul_re && (k == K_LAST)) begin
                    issue_done <= 1'b1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + KW'(1);
                end
            end

            start_cnt <= (state == S_START) ? ~start_cnt : 1'b0;
            arm_cnt   <= (state == S_ARM) ? arm_cnt + 3'd1 : 3'd0;

            if (state != S_RUN) begin
                run_cnt <= 16'd0;
            end else if (run_cnt != 16'hFFFF) begin
                run_cnt <= run_cnt + 16'd1;
            end

            inflight <= ul_re;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
        end
    end

    always_ff @(posedge iCLK) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= iUL_DATA;
        end
    end

    // Address/data buses are held at zero unless their strobe is active.
    always_comb begin
        oIN_READY   = (state == S_LOAD);
        oLD_WE      = ld_xfer;
        oLD_BANK    = ld_xfer ? k[1:0] : 2'd0;
        oLD_ADDR    = ld_xfer ? k[KW-1:2] : '0;
        oLD_DATA    = ld_xfer ? iIN_DATA : '0;
        oFHT_START  = (state == S_START);
        oUL_RE      = ul_re;
        oUL_BANK    = ul_re ? k[1:0] : 2'd0;
        oUL_ADDR    = ul_re ? k[KW-1:2] : '0;
        oOUT_VALID  = (fifo_cnt != 2'd0);
        oOUT_DATA   = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : '0;
        oOWNER      = (state == S_START) || (state == S_ARM) || (state == S_RUN);
        oBUSY       = (state != S_IDLE);
        oFRAME_DONE = (state == S_DONE);
        oERR_TMO    = err;
    end

endmodule
